// File: rtl/inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: the machine word, the ISA
// opcode constants, the instruction format enum, the output-buffer states and
// opcode -> format helpers.
package inst_encoder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  typedef logic [XLEN-1:0] word_t;

  localparam logic [OPC_W-1:0] ISA_OPCODE_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] ISA_OPCODE_OP_IMMED = 7'b0010011;
  localparam logic [OPC_W-1:0] ISA_OPCODE_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] ISA_OPCODE_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] ISA_OPCODE_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] ISA_OPCODE_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] ISA_OPCODE_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] ISA_OPCODE_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] ISA_OPCODE_JAL      = 7'b1101111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} inst_fmt_t;

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_t;

  // Unknown opcodes fall back to the R layout (raw field pass-through).
  function automatic inst_fmt_t opcode_fmt(input logic [OPC_W-1:0] opcode);
    inst_fmt_t fmt;
    case (opcode)
      ISA_OPCODE_LOAD, ISA_OPCODE_OP_IMMED, ISA_OPCODE_JALR: fmt = FMT_I;
      ISA_OPCODE_STORE:                                      fmt = FMT_S;
      ISA_OPCODE_BRANCH:                                     fmt = FMT_B;
      ISA_OPCODE_LUI, ISA_OPCODE_AUIPC:                      fmt = FMT_U;
      ISA_OPCODE_JAL:                                        fmt = FMT_J;
      default:                                               fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic opcode_known(input logic [OPC_W-1:0] opcode);
    logic known;
    case (opcode)
      ISA_OPCODE_LOAD, ISA_OPCODE_OP_IMMED, ISA_OPCODE_AUIPC, ISA_OPCODE_STORE,
      ISA_OPCODE_OP, ISA_OPCODE_LUI, ISA_OPCODE_BRANCH, ISA_OPCODE_JALR,
      ISA_OPCODE_JAL: known = 1'b1;
      default:        known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/inst_encoder_immed_pack.sv
// Combinational immediate packer: classifies the opcode into an instruction
// format and scatters the immediate into that format's bit positions (all
// other bits 0). Out-of-range immediates are silently truncated.
// Ports:
//   i_opcode    in  7   opcode field
//   i_immed     in  32  sign-extended immediate
//   o_fmt       out 3   instruction format
//   o_imm_bits  out 32  immediate placed in instruction bit positions
//   o_err       out 1   immediate not representable / unknown opcode
//                       (present only with INST_ENCODER_RANGE_CHECK_EN)
module inst_encoder_immed_pack
  import inst_encoder_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_immed,
  output inst_fmt_t   o_fmt,
  output logic [31:0] o_imm_bits
`ifdef INST_ENCODER_RANGE_CHECK_EN
  ,
  output logic        o_err
`endif
);

  inst_fmt_t w_fmt;

  assign w_fmt = opcode_fmt(i_opcode);
  assign o_fmt = w_fmt;

  // Immediate scatter per format.
  always_comb begin
    o_imm_bits = '0;
    case (w_fmt)
      FMT_I: o_imm_bits[31:20] = i_immed[11:0];
      FMT_S: begin
        o_imm_bits[31:25] = i_immed[11:5];
        o_imm_bits[11:7]  = i_immed[4:0];
      end
      FMT_B: begin
        o_imm_bits[31]    = i_immed[12];
        o_imm_bits[7]     = i_immed[11];
        o_imm_bits[30:25] = i_immed[10:5];
        o_imm_bits[11:8]  = i_immed[4:1];
      end
      FMT_U: o_imm_bits[31:12] = i_immed[31:12];
      FMT_J: begin
        o_imm_bits[31]    = i_immed[20];
        o_imm_bits[19:12] = i_immed[19:12];
        o_imm_bits[20]    = i_immed[11];
        o_imm_bits[30:21] = i_immed[10:1];
      end
      default: ;
    endcase
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  // Representable iff the bits above the field are a pure sign run.
  always_comb begin
    o_err = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: o_err = (|i_immed[31:11]) && !(&i_immed[31:11]);
      FMT_B:        o_err = ((|i_immed[31:12]) && !(&i_immed[31:12])) || i_immed[0];
      FMT_J:        o_err = ((|i_immed[31:20]) && !(&i_immed[31:20])) || i_immed[0];
      FMT_U:        o_err = |i_immed[11:0];
      default:      o_err = !opcode_known(i_opcode);
    endcase
  end
`endif

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder for the debug/boot injection path. Merges register
// and funct fields with the packed immediate and delivers words through a
// 2-entry FIFO with valid/ready on both sides; counts delivered words.
// Optional: INST_ENCODER_RANGE_CHECK_EN enables out_err range checking;
// without it out_err is tied 0.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                request handshake (in_ready registered)
//   in_opcode/rd/rs1/rs2/funct3/funct7/immed   request fields
//   out_valid/out_ready              result handshake
//   out_inst, out_err                encoded word and range error
//   inst_cnt                         wrapping count of output handshakes
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_immed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] inst_cnt
);

  // Buffer payload carries the error bit only when it can be nonzero.
`ifdef INST_ENCODER_RANGE_CHECK_EN
  localparam int unsigned PAY_W = XLEN + 1;
`else
  localparam int unsigned PAY_W = XLEN;
`endif

  inst_fmt_t        w_fmt;
  word_t            w_imm_bits;
  word_t            w_enc;
  logic [PAY_W-1:0] w_pay;
  logic             w_push;
  logic             w_pop;

  buf_state_t       r_state;
  buf_state_t       w_state_nxt;
  logic [PAY_W-1:0] r_head;
  logic [PAY_W-1:0] r_tail;
  logic [PAY_W-1:0] w_head_nxt;
  logic [PAY_W-1:0] w_tail_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic             r_in_ready;
  logic             w_in_ready_nxt;
  logic [CNT_W-1:0] r_cnt;

`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic w_err;

  inst_encoder_immed_pack u_immed_pack (
    .i_opcode   (in_opcode),
    .i_immed    (in_immed),
    .o_fmt      (w_fmt),
    .o_imm_bits (w_imm_bits),
    .o_err      (w_err)
  );

  assign w_pay   = {w_err, w_enc};
  assign out_err = r_head[XLEN];
`else
  inst_encoder_immed_pack u_immed_pack (
    .i_opcode   (in_opcode),
    .i_immed    (in_immed),
    .o_fmt      (w_fmt),
    .o_imm_bits (w_imm_bits)
  );

  assign w_pay   = w_enc;
  assign out_err = 1'b0;
`endif

  // Field merge: place rd/rs/funct per format; unused fields stay 0.
  always_comb begin
    w_enc = '0;
    case (w_fmt)
      FMT_I:        w_enc = w_imm_bits | {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S, FMT_B: w_enc = w_imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
      FMT_U, FMT_J: w_enc = w_imm_bits | {20'b0, in_rd, in_opcode};
      default:      w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    endcase
  end

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  // Buffer FSM next state; head is always the word presented on out_inst.
  always_comb begin
    w_state_nxt     = r_state;
    w_head_nxt      = r_head;
    w_tail_nxt      = r_tail;
    w_out_valid_nxt = r_out_valid;
    w_in_ready_nxt  = r_in_ready;
    case (r_state)
      BUF_EMPTY: begin
        if (w_push) begin
          w_state_nxt = BUF_ONE;
          w_head_nxt  = w_pay;
        end
      end
      BUF_ONE: begin
        case ({w_push, w_pop})
          2'b11: w_head_nxt = w_pay;
          2'b10: begin
            w_state_nxt = BUF_TWO;
            w_tail_nxt  = w_pay;
          end
          2'b01: w_state_nxt = BUF_EMPTY;
          default: ;
        endcase
      end
      BUF_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_state_nxt = BUF_ONE;
          w_head_nxt  = r_tail;
        end
      end
      default: w_state_nxt = BUF_EMPTY;
    endcase
    w_out_valid_nxt = (w_state_nxt != BUF_EMPTY);
    w_in_ready_nxt  = (w_state_nxt != BUF_TWO);
  end

  // Buffer state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BUF_EMPTY;
      r_head      <= '0;
      r_tail      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // Delivered-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_inst  = r_head[XLEN-1:0];
  assign inst_cnt  = r_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encodings, back-pressure,
// mid-operation reset and a randomized scoreboard run.
`timescale 1ns/1ps
module tb_inst_encoder;

  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_immed;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] inst_cnt;

  int               n_checks;
  int               n_errors;
  exp_t             q[$];
  exp_t             cur_exp;
  exp_t             mon_e;
  logic [CNT_W-1:0] exp_cnt;
  logic             bp_en;
  logic [6:0]       ops [10];

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_immed  (in_immed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .inst_cnt  (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=0x%08h exp=0x%08h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference encoder built bit-by-bit from the RV32I layouts.
  function automatic logic [31:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    w[6:0] = op;
    case (op)
      7'h03, 7'h13, 7'h67: begin
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
      end
      7'h23: begin
        w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
        w[31:25] = imm[11:5]; w[11:7] = imm[4:0];
      end
      7'h63: begin
        w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
        w[31] = imm[12]; w[7] = imm[11]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1];
      end
      7'h37, 7'h17: begin
        w[11:7] = rd; w[31:12] = imm[31:12];
      end
      7'h6F: begin
        w[11:7] = rd; w[31] = imm[20]; w[19:12] = imm[19:12];
        w[20] = imm[11]; w[30:21] = imm[10:1];
      end
      default: begin
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = f7;
      end
    endcase
    return w;
  endfunction

  // Reference range check expressed as signed value ranges.
  function automatic logic model_err(input logic [6:0] op, input logic [31:0] imm);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    int s;
    s = $signed(imm);
    case (op)
      7'h03, 7'h13, 7'h67, 7'h23: return (s < -2048) || (s > 2047);
      7'h63: return (s < -4096) || (s > 4095) || imm[0];
      7'h6F: return (s < -1048576) || (s > 1048575) || imm[0];
      7'h37, 7'h17: return imm[11:0] != 12'd0;
      7'h33: return 1'b0;
      default: return 1'b1;
    endcase
`else
    return (op == 7'h00) && (imm == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] e_inst, input logic e_err);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_immed = imm;
    cur_exp.inst = e_inst;
    cur_exp.err  = e_err;
    in_valid = 1'b1;
  endtask

  // Hold in_valid until accepted (bounded), return at posedge+1.
  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] e_inst, input logic e_err);
    drive(op, rd, rs1, rs2, f3, f7, imm, e_inst, e_err);
    wait_accept();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted request, pop/compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("out_inst", out_inst, mon_e.inst);
          check("out_err", 32'(out_err), 32'(mon_e.err));
          exp_cnt = exp_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Random consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        e4_err;

    n_checks = 0; n_errors = 0; exp_cnt = '0; bp_en = 1'b0;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_immed = '0; cur_exp = '0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_inst_cnt", 32'(inst_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodings.
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    check("addi_valid_next_cycle", 32'(out_valid), 32'd1);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0000_0463, 1'b0);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_50B7, 1'b0);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    e4_err = 1'b1;
`else
    e4_err = 1'b0;
`endif
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0013, e4_err);
    drain();
    check("cnt_directed", 32'(inst_cnt), 32'd5);

    // Back-pressure: two fill the buffer, third is held.
    apply_reset();
    out_ready = 1'b0;
    send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0051_8113, 1'b0);
    send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 32'h0051_2623, 1'b0);
    drive(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_hold_inst", out_inst, 32'h0051_8113);
    check("full_q_depth", 32'(q.size()), 32'd2);
    out_ready = 1'b1;
    wait_accept();
    drain();
    check("cnt_after_bp", 32'(inst_cnt), 32'd3);

    // Reset while the buffer holds two entries.
    out_ready = 1'b0;
    send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0051_8113, 1'b0);
    send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 32'h0051_2623, 1'b0);
    check("two_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_cnt = '0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_inst_cnt", 32'(inst_cnt), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure.
    bp_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op  = ops[$urandom_range(0, 9)];
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3  = 3'($urandom); f7  = 7'($urandom);
      imm = $urandom;
      if (i % 3 == 1) imm = {{20{imm[11]}}, imm[11:0]};
      if (i % 4 == 2) imm[0] = 1'b0;
      send(op, rd, rs1, rs2, f3, f7, imm,
           model_enc(op, rd, rs1, rs2, f3, f7, imm), model_err(op, imm));
    end
    bp_en = 1'b0;
    out_ready = 1'b1;
    drain();
    check("cnt_random", 32'(inst_cnt), 32'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
